dispatch_credit_ctrl: RTL and testbench

//  WIDTH-way successor to the single-issue DP_IS hazard logic. Each cycle it decides how many IF/ID

---
 rtl/dispatch_credit_ctrl_pkg.sv | 12 +
 rtl/credit_counter.sv | 24 ++
 rtl/dispatch_credit_ctrl.sv | 91 +++++++++
 tb/tb_dispatch_credit_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/dispatch_credit_ctrl_pkg.sv
// dispatch_credit_ctrl_pkg: shared dispatch constants, FSM state type and IF/ID hazard packet
package dispatch_credit_ctrl_pkg;
   localparam int DISPATCH_WIDTH = 2;
   localparam int ROB_DEPTH = 32;
   localparam int RS_DEPTH = 16;
   typedef enum logic {DC_NORMAL = 1'b0, DC_RECOVER = 1'b1} dc_state_e;
   typedef struct packed {
      logic struc_hazard;
      logic next_struc_hazard;
      logic [$clog2(DISPATCH_WIDTH+1)-1:0] dp_cnt;
   } dc2ifid_packet_t;
endpackage

// File: rtl/credit_counter.sv
// credit_counter: one free-credit counter with take/return/flush, saturation and overflow flag
module credit_counter #(
   parameter int DEPTH = 16,
   parameter int CW = 2,
   localparam int NW = $clog2(DEPTH+1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [CW-1:0] take,
   input  logic [CW-1:0] ret,
   input  logic          flush,
   output logic [NW-1:0] cnt,
   output logic [NW-1:0] nxt,
   output logic          ovf
);
   logic [NW:0] sum;
   always_comb begin
      sum = {1'b0, cnt} - (NW+1)'(take) + (NW+1)'(ret);
      ovf = !flush && sum > (NW+1)'(DEPTH);
      nxt = (flush || ovf) ? NW'(DEPTH) : sum[NW-1:0];
   end
   always_ff @(posedge clock)
      cnt <= !reset ? NW'(DEPTH) : nxt;
endmodule

// File: rtl/dispatch_credit_ctrl.sv
// dispatch_credit_ctrl: credit-based multi-lane dispatch grant, ROB tail allocation and squash recovery
module dispatch_credit_ctrl
   import dispatch_credit_ctrl_pkg::*;
#(
   parameter int WIDTH = DISPATCH_WIDTH,
   parameter int ROB_DEPTH = dispatch_credit_ctrl_pkg::ROB_DEPTH,
   parameter int RS_DEPTH = dispatch_credit_ctrl_pkg::RS_DEPTH,
   parameter int SQUASH_CYCLES = 1,
   localparam int CW = $clog2(WIDTH+1),
   localparam int RW = $clog2(ROB_DEPTH),
   localparam int FW = $clog2(ROB_DEPTH+1),
   localparam int SW = $clog2(RS_DEPTH+1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic [WIDTH-1:0]    inst_valid,
   input  logic [CW-1:0]       rob_retire_cnt,
   input  logic [CW-1:0]       rs_free_cnt,
   input  logic                squash,
   output logic [WIDTH-1:0]    dp_grant,
   output logic [CW-1:0]       dp_cnt,
   output logic [WIDTH*RW-1:0] dp_rob_idx,
   output logic [FW-1:0]       rob_free,
   output logic [SW-1:0]       rs_free,
   output logic                struc_hazard,
   output logic                next_struc_hazard,
   output logic                recovering,
   output logic                credit_err
);
   localparam int QW = $clog2(SQUASH_CYCLES+1);
   dc_state_e     state;
   logic [QW-1:0] rcnt;
   logic [RW-1:0] head, tail;
   logic [CW-1:0] run, k;
   logic          alive, rob_ovf, rs_ovf;
   logic [FW-1:0] rob_nxt;
   logic [SW-1:0] rs_nxt;
   int            lim;
   // grant only the oldest contiguous run of valid lanes that both credit pools can absorb
   always_comb begin
      run = '0;
      alive = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         alive = alive & inst_valid[i];
         run = alive ? CW'(i+1) : run;
      end
      lim = int'(run);
      lim = int'(rob_free) < lim ? int'(rob_free) : lim;
      lim = int'(rs_free) < lim ? int'(rs_free) : lim;
      k = (!reset || stall || squash || state != DC_NORMAL) ? '0 : CW'(lim);
      dp_grant = '0;
      dp_rob_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         dp_grant[i] = i < int'(k);
         dp_rob_idx[i*RW +: RW] = tail + RW'(i);
      end
   end
   assign dp_cnt = k;
   assign recovering = state == DC_RECOVER;
   assign struc_hazard = recovering || int'(rob_free) < WIDTH || int'(rs_free) < WIDTH;
   assign next_struc_hazard = recovering || int'(rob_nxt) < WIDTH || int'(rs_nxt) < WIDTH;
   credit_counter #(.DEPTH(ROB_DEPTH), .CW(CW)) u_rob (
      .clock(clock), .reset(reset), .take(k), .ret(rob_retire_cnt), .flush(squash),
      .cnt(rob_free), .nxt(rob_nxt), .ovf(rob_ovf)
   );
   credit_counter #(.DEPTH(RS_DEPTH), .CW(CW)) u_rs (
      .clock(clock), .reset(reset), .take(k), .ret(rs_free_cnt), .flush(squash),
      .cnt(rs_free), .nxt(rs_nxt), .ovf(rs_ovf)
   );
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= DC_NORMAL;
         rcnt <= '0;
         head <= '0;
         tail <= '0;
         credit_err <= 1'b0;
      end else begin
         head <= squash ? '0 : head + RW'(rob_retire_cnt);
         tail <= squash ? '0 : tail + RW'(k);
         credit_err <= credit_err | rob_ovf | rs_ovf;
         if (squash) begin
            state <= DC_RECOVER;
            rcnt <= QW'(SQUASH_CYCLES-1);
         end else if (state == DC_RECOVER) begin
            state <= rcnt == '0 ? DC_NORMAL : DC_RECOVER;
            rcnt <= rcnt == '0 ? rcnt : rcnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// tb_dispatch_credit_ctrl: directed and random stimulus checked against a credit/pointer reference model
module tb_dispatch_credit_ctrl;
   localparam int W = 2, RD = 32, SD = 16, SQ = 2;
   logic       clock = 1'b0;
   logic       reset, stall, squash;
   logic [1:0] inst_valid, rob_retire_cnt, rs_free_cnt;
   logic [1:0] dp_grant, dp_cnt;
   logic [9:0] dp_rob_idx;
   logic [5:0] rob_free;
   logic [4:0] rs_free;
   logic       struc_hazard, next_struc_hazard, recovering, credit_err;
   int         tests = 0, fails = 0;
   int         m_rob, m_rs, m_tail, m_rec;
   bit         m_err;

   dispatch_credit_ctrl #(.WIDTH(W), .ROB_DEPTH(RD), .RS_DEPTH(SD), .SQUASH_CYCLES(SQ)) dut (
      .clock(clock), .reset(reset), .stall(stall), .inst_valid(inst_valid),
      .rob_retire_cnt(rob_retire_cnt), .rs_free_cnt(rs_free_cnt), .squash(squash),
      .dp_grant(dp_grant), .dp_cnt(dp_cnt), .dp_rob_idx(dp_rob_idx), .rob_free(rob_free),
      .rs_free(rs_free), .struc_hazard(struc_hazard), .next_struc_hazard(next_struc_hazard),
      .recovering(recovering), .credit_err(credit_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic rst, input logic st, input logic [1:0] v,
                      input logic [1:0] rr, input logic [1:0] rf, input logic sq);
      int run, k, nr, ns;
      logic [9:0] idx;
      bit oe;
      reset = rst; stall = st; inst_valid = v; rob_retire_cnt = rr; rs_free_cnt = rf; squash = sq;
      @(negedge clock);
      run = 0;
      while (run < W && v[run]) run++;
      k = run;
      if (m_rob < k) k = m_rob;
      if (m_rs < k) k = m_rs;
      if (!rst || st || sq || m_rec > 0) k = 0;
      for (int i = 0; i < W; i++) idx[i*5 +: 5] = 5'((m_tail + i) % RD);
      chk("dp_grant", 32'(dp_grant), (1 << k) - 1);
      chk("dp_cnt", 32'(dp_cnt), k);
      chk("dp_rob_idx", 32'(dp_rob_idx), 32'(idx));
      chk("rob_free", 32'(rob_free), m_rob);
      chk("rs_free", 32'(rs_free), m_rs);
      chk("struc_hazard", 32'(struc_hazard), 32'(m_rec > 0 || m_rob < W || m_rs < W));
      chk("recovering", 32'(recovering), 32'(m_rec > 0));
      chk("credit_err", 32'(credit_err), 32'(m_err));
      oe = 0;
      nr = sq ? RD : m_rob - k + int'(rr);
      ns = sq ? SD : m_rs - k + int'(rf);
      if (nr > RD) begin nr = RD; oe = 1; end
      if (ns > SD) begin ns = SD; oe = 1; end
      if (rst) chk("next_struc_hazard", 32'(next_struc_hazard), 32'(m_rec > 0 || nr < W || ns < W));
      @(posedge clock);
      if (!rst) begin
         m_rob = RD; m_rs = SD; m_tail = 0; m_rec = 0; m_err = 0;
      end else begin
         m_rob = nr; m_rs = ns; m_err = m_err | oe;
         m_tail = sq ? 0 : (m_tail + k) % RD;
         m_rec = sq ? SQ : (m_rec > 0 ? m_rec - 1 : 0);
      end
      #1;
   endtask

   initial begin
      int rmax, smax;
      m_rob = RD; m_rs = SD; m_tail = 0; m_rec = 0; m_err = 0;
      reset = 0; stall = 0; squash = 0; inst_valid = '0; rob_retire_cnt = '0; rs_free_cnt = '0;
      #1;
      // reset, then full-width dispatch until the RS credits run out
      cyc(0, 0, 2'b11, 0, 0, 0);
      cyc(0, 0, 2'b11, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 0, 2'b11, 0, 0, 0);
      chk("rs_exhausted", 32'(rs_free), 0);
      // gap at lane 0, then single-lane grant with one RS credit
      cyc(0, 0, 2'b00, 0, 0, 0);
      cyc(1, 0, 2'b10, 0, 0, 0);
      for (int i = 0; i < 7; i++) cyc(1, 0, 2'b11, 0, 0, 0);
      cyc(1, 0, 2'b01, 0, 0, 0);
      cyc(1, 0, 2'b01, 0, 0, 0);
      cyc(1, 0, 2'b01, 0, 0, 0);
      // drain ROB to one credit with RS refilled each cycle, tail wraps 31->0
      cyc(0, 0, 2'b00, 0, 0, 0);
      for (int i = 0; i < 15; i++) cyc(1, 0, 2'b11, 0, 2, 0);
      cyc(1, 0, 2'b01, 0, 1, 0);
      cyc(1, 0, 2'b11, 2, 0, 0);
      cyc(1, 0, 2'b11, 2, 2, 0);
      // squash with credits partly used: two recovery cycles, then full grants
      cyc(1, 0, 2'b11, 1, 1, 1);
      cyc(1, 0, 2'b11, 0, 0, 0);
      cyc(1, 0, 2'b11, 0, 0, 0);
      cyc(1, 0, 2'b11, 0, 0, 0);
      cyc(1, 0, 2'b11, 0, 0, 1);
      cyc(1, 0, 2'b11, 0, 0, 1);
      cyc(1, 0, 2'b11, 0, 0, 0);
      cyc(1, 0, 2'b11, 0, 0, 0);
      // overflow returns at full credit set the sticky error
      cyc(0, 0, 2'b00, 0, 0, 0);
      cyc(1, 1, 2'b00, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 2'b11, 0, 0, 0);
      // reset during a stalled burst
      cyc(1, 1, 2'b11, 1, 1, 0);
      cyc(0, 1, 2'b11, 1, 1, 0);
      cyc(1, 0, 2'b11, 0, 0, 0);
      for (int n = 0; n < 400; n++) begin
         rmax = RD - m_rob; rmax = rmax > W ? W : rmax;
         smax = SD - m_rs;  smax = smax > W ? W : smax;
         cyc($urandom_range(99) != 0, $urandom_range(4) == 0, 2'($urandom_range(3)),
             2'($urandom_range(rmax)), 2'($urandom_range(smax)), $urandom_range(19) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
